// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl
// Description : Coefficient loader and one-sample-in-flight sequencer for a
//               direct-form FIR with a LAT-cycle result latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl #(
    parameter int DELAYS = 3,
    parameter int N      = 32,
    parameter int LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coef_valid,
    input  logic [N-1:0]          coef_data,
    output logic                  coef_ready,
    input  logic                  s_valid,
    input  logic [N-1:0]          s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [N-1:0]          m_data,
    input  logic                  m_ready,
    output logic [(DELAYS+1)*N-1:0] fir_b,
    output logic [N-1:0]          fir_x,
    output logic                  fir_ena,
    output logic                  fir_rst,
    input  logic [N-1:0]          fir_y,
    output logic                  cfg_done
);

    localparam int c_WPW = (DELAYS > 0) ? $clog2(DELAYS + 1) : 1;
    localparam logic [c_WPW-1:0] c_WPTR_LAST = c_WPW'(DELAYS);
    localparam logic [3:0]       c_CNT_LAST  = 4'(LAT);

    localparam logic [1:0] c_LOAD = 2'd0;
    localparam logic [1:0] c_IDLE = 2'd1;
    localparam logic [1:0] c_BUSY = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    logic [1:0]             r_state;
    logic [c_WPW-1:0]       r_wptr;
    logic                   r_commit_pend;
    logic [3:0]             r_cnt;
    logic [(DELAYS+1)*N-1:0] r_fir_b;
    logic [N-1:0]           r_fir_x;
    logic [N-1:0]           r_m_data;
    logic                   r_m_valid;
    logic                   r_fir_ena;
    logic                   r_fir_rst;
    logic                   r_cfg_done;

    logic                   w_coef_fire;
    logic                   w_s_fire;
    logic                   w_last;
    logic                   w_direct_commit;
    logic                   w_defer;
    logic                   w_pend_commit;
    logic                   w_commit;
    logic [(DELAYS+1)*N-1:0] w_new_b;

    assign coef_ready  = ~r_commit_pend;
    // The cycle carrying fir_rst is kept free of samples so the delay line is
    // cleared before the first sample under the new coefficients.
    assign s_ready     = (r_state == c_IDLE) & ~r_commit_pend & ~r_fir_rst;
    assign w_coef_fire = coef_valid & coef_ready;
    assign w_s_fire    = s_valid & s_ready;
    assign w_last      = (r_wptr == c_WPTR_LAST);

    assign w_direct_commit = w_coef_fire & w_last &
                             ((r_state == c_LOAD) | ((r_state == c_IDLE) & ~w_s_fire));
    assign w_defer         = w_coef_fire & w_last & ~w_direct_commit;
    assign w_pend_commit   = (r_state == c_IDLE) & r_commit_pend;
    assign w_commit        = w_direct_commit | w_pend_commit;

    genvar k;
    generate
        for (k = 0; k <= DELAYS; k++) begin : g_shadow
            logic [N-1:0] r_word;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_coef_fire && (r_wptr == c_WPW'(k))) begin
                    r_word <= coef_data;
                end
            end

            if (k == DELAYS) begin : g_last_word
                // A direct commit happens on the same edge as the final write,
                // so the final word is forwarded from the input.
                assign w_new_b[k*N +: N] = r_commit_pend ? r_word : coef_data;
            end else begin : g_word
                assign w_new_b[k*N +: N] = r_word;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_LOAD;
            r_wptr        <= '0;
            r_commit_pend <= 1'b0;
            r_cnt         <= '0;
            r_fir_b       <= '0;
            r_fir_x       <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_fir_ena     <= 1'b0;
            r_fir_rst     <= 1'b1;
            r_cfg_done    <= 1'b0;
        end else begin
            r_fir_ena <= 1'b0;
            r_fir_rst <= 1'b0;

            if (w_commit) begin
                r_wptr <= '0;
            end else if (w_coef_fire && !w_last) begin
                r_wptr <= r_wptr + 1'b1;
            end

            if (w_defer) begin
                r_commit_pend <= 1'b1;
            end else if (w_pend_commit) begin
                r_commit_pend <= 1'b0;
            end

            if (w_commit) begin
                r_fir_b    <= w_new_b;
                r_fir_rst  <= 1'b1;
                r_cfg_done <= 1'b1;
            end

            case (r_state)
                c_LOAD: begin
                    if (w_direct_commit) begin
                        r_state <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (w_s_fire) begin
                        r_fir_x   <= s_data;
                        r_fir_ena <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    // r_cnt is 0 in the fir_ena cycle; fir_y is valid LAT cycles later.
                    if (r_cnt == c_CNT_LAST) begin
                        r_m_data  <= fir_y;
                        r_m_valid <= 1'b1;
                        r_state   <= c_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_LOAD;
                end
            endcase
        end
    end

    assign fir_b    = r_fir_b;
    assign fir_x    = r_fir_x;
    assign fir_ena  = r_fir_ena;
    assign fir_rst  = r_fir_rst;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign cfg_done = r_cfg_done;

endmodule
`default_nettype wire
